// File: rtl/package_cam.sv
// Shared camera/display-path definitions: TMDS symbol type, control codes and
// helpers shared by the DVI output stage.
package package_cam;

  typedef logic [9:0] t_tmds_symbol;

  localparam int unsigned c_tmds_channels = 3;
  localparam int unsigned c_tmds_disp_w   = 6;

  localparam t_tmds_symbol c_tmds_ctrl_00 = 10'b1101010100;
  localparam t_tmds_symbol c_tmds_ctrl_01 = 10'b0010101011;
  localparam t_tmds_symbol c_tmds_ctrl_10 = 10'b0101010100;
  localparam t_tmds_symbol c_tmds_ctrl_11 = 10'b1010101011;

  // Stage-2 symbol selection for one channel.
  typedef enum logic [1:0] {
    TmdsSelCtrl,
    TmdsSelBalanced,
    TmdsSelInvert,
    TmdsSelKeep
  } t_tmds_sel;

  function automatic logic [3:0] tmds_popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic t_tmds_symbol tmds_ctrl_symbol(input logic [1:0] c);
    t_tmds_symbol sym;
    unique case (c)
      2'b00:   sym = c_tmds_ctrl_00;
      2'b01:   sym = c_tmds_ctrl_01;
      2'b10:   sym = c_tmds_ctrl_10;
      default: sym = c_tmds_ctrl_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: stage 1 transition-minimises the byte into q_m, stage 2
// DC-balances it against the running disparity and registers the symbol.
module tmds_channel_encoder
  import package_cam::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_de,
  input  logic [1:0]   i_c,
  input  logic [7:0]   i_d,
  output t_tmds_symbol o_symbol
);

  typedef logic signed [c_tmds_disp_w-1:0] t_disp;

  localparam t_disp c_zero     = t_disp'(0);
  localparam t_disp c_two      = t_disp'(2);
  localparam t_disp c_eight    = t_disp'(8);
  localparam t_disp c_disp_max = t_disp'(10);

  // Stage 1: transition minimisation.
  logic [3:0] n1d;
  logic       xnor_mode;
  logic       chain;
  logic [8:0] qm_d;
  logic [8:0] qm_q;
  logic       de_q;
  logic [1:0] c_q;

  always_comb begin
    n1d       = tmds_popcount8(i_d);
    xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !i_d[0]);
    qm_d      = '0;
    chain     = i_d[0];
    qm_d[0]   = chain;
    for (int i = 1; i < 8; i++) begin
      chain   = xnor_mode ? ~(chain ^ i_d[i]) : (chain ^ i_d[i]);
      qm_d[i] = chain;
    end
    qm_d[8] = ~xnor_mode;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      qm_q <= '0;
      de_q <= 1'b0;
      c_q  <= 2'b00;
    end else begin
      qm_q <= qm_d;
      de_q <= i_de;
      c_q  <= i_c;
    end
  end

  // Stage 2: DC balancing.
  logic [3:0]   n1_raw;
  t_disp        n1;
  t_disp        n0;
  t_disp        diff;
  t_disp        cnt_d;
  t_disp        cnt_q;
  t_tmds_sel    sel;
  t_tmds_symbol sym_d;
  t_tmds_symbol sym_q;

  always_comb begin
    n1_raw = tmds_popcount8(qm_q[7:0]);
    n1     = t_disp'(n1_raw);
    n0     = c_eight - n1;
    diff   = n1 - n0;

    if (!de_q) begin
      sel = TmdsSelCtrl;
    end else if ((cnt_q == c_zero) || (n1 == n0)) begin
      sel = TmdsSelBalanced;
    end else if (((cnt_q > c_zero) && (n1 > n0)) || ((cnt_q < c_zero) && (n0 > n1))) begin
      sel = TmdsSelInvert;
    end else begin
      sel = TmdsSelKeep;
    end
  end

  always_comb begin
    sym_d = tmds_ctrl_symbol(c_q);
    cnt_d = c_zero;
    unique case (sel)
      TmdsSelCtrl: begin
        sym_d = tmds_ctrl_symbol(c_q);
        cnt_d = c_zero;
      end
      TmdsSelBalanced: begin
        sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end
      TmdsSelInvert: begin
        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + (qm_q[8] ? c_two : c_zero) - diff;
      end
      default: begin
        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q + diff - (qm_q[8] ? c_zero : c_two);
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sym_q <= c_tmds_ctrl_00;
      cnt_q <= c_zero;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_symbol = sym_q;

  // Disparity is bounded by the encoding rules; a violation means broken arithmetic.
  a_disp_bounded : assert property (@(posedge i_clk) disable iff (i_rst)
    (cnt_q <= c_disp_max) && (cnt_q >= -c_disp_max));

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: three independent channel encoders, fixed two-cycle
// latency; sync travels on channel 0 only.
module dvi_tmds_encoder
  import package_cam::*;
#(
  parameter int unsigned p_pipe_stages = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_de,
  input  logic                                   i_hsync,
  input  logic                                   i_vsync,
  input  logic [c_tmds_channels-1:0][7:0]        i_data,
  output logic [c_tmds_channels-1:0][9:0]        o_symbol
);

  if (p_pipe_stages != 2) begin : g_bad_pipe
    $error("dvi_tmds_encoder: only p_pipe_stages == 2 is supported");
  end

  logic [c_tmds_channels-1:0][1:0] ctrl;

  assign ctrl[0] = {i_vsync, i_hsync};
  assign ctrl[1] = 2'b00;
  assign ctrl[2] = 2'b00;

  for (genvar ch = 0; ch < c_tmds_channels; ch++) begin : g_ch
    tmds_channel_encoder u_enc (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_de     (i_de),
      .i_c      (ctrl[ch]),
      .i_d      (i_data[ch]),
      .o_symbol (o_symbol[ch])
    );
  end

endmodule

// File: doc/dvi_tmds_encoder.md
Name: dvi_tmds_encoder

Overview:
- Downstream stage of the camera/VGA display path.
- Consumes the pixel-clock-domain video stream: de, hsync, vsync and 8-bit R/G/B.
- Produces three 10-bit TMDS symbols per pixel clock, per DVI 1.0 (8b/10b transition-minimised, DC-balanced).
- Symbols go to the existing DDR serializer/output-pin stage; serialization is out of scope here.

Parameters:
- p_pipe_stages, 2, register stages from input to o_symbol. Only 2 is supported; elaboration error otherwise.

Ports:
- i_clk  in  1  pixel clock (same clock that drives the VGA timing generator)
- i_rst  in  1  synchronous, active-high reset
- i_de  in  1  active video
- i_hsync  in  1  horizontal sync, already polarity-correct
- i_vsync  in  1  vertical sync, already polarity-correct
- i_data  in  [7:0] x3  pixel colour; index 2=R, 1=G, 0=B
- o_symbol  out  [9:0] x3  TMDS symbols; index 2=ch2 (R), 1=ch1 (G), 0=ch0 (B)

Behaviour:
- Reset: i_rst is synchronous, active-high, on i_clk.
  - While asserted, all o_symbol = 10'b1101010100 (control code 00).
  - All disparity counters = 0; pipeline de flags = 0.
- Latency: inputs sampled at edge N appear on o_symbol after edge N+2. Fixed, no stalls, no handshake; one symbol per channel every cycle.
- Control mapping: ch0 carries {c1,c0} = {i_vsync, i_hsync}; ch1 and ch2 carry c=00.
- Stage 1, per channel, registered:
  - n1d = popcount(D).
  - XNOR mode when n1d>4, or n1d==4 with D[0]==0; otherwise XOR mode.
  - q_m[0]=D[0]; q_m[i] = q_m[i-1] XOR D[i] (XOR mode) or XNOR D[i] (XNOR mode).
  - q_m[8]=1 for XOR mode, 0 for XNOR mode.
  - de and the control pair are registered alongside.
- Stage 2, per channel: n1/n0 = ones/zeros of q_m[7:0]; cnt is a 6-bit signed running disparity.
  - de=0: output the control symbol. 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011. cnt<=0.
  - de=1, cnt==0 or n1==n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - de=1, (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0-n1).
  - Otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1-n0) - 2*(~q_m[8]).
- Width rules: all disparity arithmetic is signed 6-bit and never saturates. |cnt| ≤ 10 holds by construction; an assertion checks it.
- de rising edge: the first data symbol uses cnt=0, because blanking cleared it.
- Reset mid-line: outputs drop to the reset control symbol on the next edge. Pipeline contents are discarded.
- Channels are independent; only ch0 sees sync, so ch1 and ch2 must not depend on sync inputs.

Decomposition:
- Shared package package_cam gains:
  - typedef t_tmds_symbol (logic [9:0]);
  - constants c_tmds_ctrl_00, c_tmds_ctrl_01, c_tmds_ctrl_10, c_tmds_ctrl_11;
  - constant c_tmds_disp_w = 6.
- One sub-module, tmds_channel_encoder. It takes clk, rst, de, c[1:0] and d[7:0] and implements both stages for one channel; the top instantiates it three times.

Test Plan:
- Reset: hold i_rst 3 cycles with random inputs → every o_symbol = 1101010100 on each of those cycles; the first post-reset control output appears 2 cycles after release.
- Control codes: de=0, step {vsync,hsync} through 00, 01, 10, 11 → ch0 shows 1101010100, 0010101011, 0101010100, 1010101011 two cycles later; ch1 and ch2 stay 1101010100.
- Zeros: after blanking, de=1 with data 0x00 on ch0 for 2 cycles → symbols 0100000000 (cnt -8), then 1111111111 (cnt +2).
- Ones: after blanking, data 0xFF → symbol 1000000000, cnt = -8.
- DC balance: 10,000 random pixels with de=1 against a reference model → bit-exact symbols. Running ones-minus-zeros over emitted symbols stays within ±10. Decoding each symbol recovers the original byte.
- Reset and blanking mid-line:
  - Assert i_rst during active video → symbol stream returns to reset code next cycle.
  - After de drops for 1 cycle → next data symbol encodes as if cnt=0 (matches model).
